spi_txn_arbiter: RTL

//  Shares one SPI master between NUM_REQ requesters, e.g. the A2D poller, the inertial

---
 rtl/spi_arb_pkg.sv | 27 ++
 rtl/spi_txn_arbiter_rr_pick.sv | 52 +++++
 rtl/spi_txn_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
//   Shared types and constants for the SPI transaction arbiter.
//   - arb_state_t      : FSM encoding (IDLE, LAUNCH, BUSY, CAPTURE, RESP)
//   - SPI_W            : width of SPI command / response words
//   - ERR_DATA_DEFAULT : response word returned when a transaction times out
// ---------------------------------------------------------------------------
package spi_arb_pkg;

  localparam int SPI_W = 16;

  localparam logic [SPI_W-1:0] ERR_DATA_DEFAULT = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    BUSY    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority picker. Searches req starting at
//   (last_idx + 1) mod NUM_REQ and wrapping upward; the first set bit wins.
//   Ports:
//     req      in   NUM_REQ  request vector
//     last_idx in   IDX_W    index served most recently
//     any      out  1        at least one request is pending
//     idx      out  IDX_W    winning index (0 when any is low)
// ---------------------------------------------------------------------------
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // cand[k] is the requester examined at search distance k+1 from last_idx;
  // hit[k] says whether that requester is asking.
  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      // One spare bit holds last_idx + offset (at most 2*NUM_REQ-1) before
      // the single conditional subtract that performs the modulo.
      logic [IDX_W:0] sum;
      assign sum = {1'b0, last_idx} + (IDX_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                        ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                        : sum[IDX_W-1:0];
      assign hit[gi] = req[cand[gi]];
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the nearest hit
  // overrides everything after it.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
//   Shares one SPI master between NUM_REQ requesters with round-robin
//   grants. Each grant issues one wrt+cmd to the master, waits for done
//   (or a watchdog timeout), then returns the response word and a
//   one-cycle ack to the winner.
//   Ports:
//     clk          in   1              system clock, posedge
//     rst          in   1              asynchronous active-high reset
//     req          in   NUM_REQ        level request per requester
//     cmd_in       in   16*NUM_REQ     command for requester i at [16*i+:16]
//     grant        out  NUM_REQ        one-hot, grant edge through ack cycle
//     ack          out  NUM_REQ        one-cycle pulse to the winner
//     rsp_data     out  16             response word, valid with ack
//     err          out  1              timeout flag, valid with ack
//     busy         out  1              FSM not in IDLE
//     spi_wrt      out  1              one-cycle write strobe to SPI master
//     spi_cmd      out  16             command to SPI master, held while busy
//     spi_done     in   1              transaction complete from SPI master
//     spi_rd_data  in   16             read data, valid cycle after spi_done
// ---------------------------------------------------------------------------
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int               NUM_REQ  = 3,
  parameter int               TIMEOUT  = 2048,
  parameter logic [SPI_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [SPI_W*NUM_REQ-1:0] cmd_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic [SPI_W-1:0]         rsp_data,
  output logic                     err,
  output logic                     busy,
  output logic                     spi_wrt,
  output logic [SPI_W-1:0]         spi_cmd,
  input  logic                     spi_done,
  input  logic [SPI_W-1:0]         spi_rd_data
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  arb_state_t       state_reg;
  logic [IDX_W-1:0] cur_idx_reg;
  logic [IDX_W-1:0] last_idx_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             err_flag_reg;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_idx (last_idx_reg),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Outputs decoded from state. grant is already one-hot on cur_idx and
  // stays high through RESP, so ack is simply grant gated by RESP.
  always_comb begin
    spi_wrt = (state_reg == LAUNCH);
    busy    = (state_reg != IDLE);
    ack     = (state_reg == RESP) ? grant : '0;
    err     = (state_reg == RESP) & err_flag_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cur_idx_reg  <= '0;
      last_idx_reg <= IDX_W'(NUM_REQ - 1);
      timer_reg    <= '0;
      err_flag_reg <= 1'b0;
      grant        <= '0;
      spi_cmd      <= '0;
      rsp_data     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            // The command is captured only here; later cmd_in changes by
            // the requester cannot disturb the transaction in flight.
            cur_idx_reg <= pick_idx;
            spi_cmd     <= cmd_in[int'(pick_idx)*SPI_W +: SPI_W];
            grant       <= NUM_REQ'(1) << pick_idx;
            state_reg   <= LAUNCH;
          end
        end

        LAUNCH: begin
          timer_reg <= TMR_W'(TIMEOUT - 1);
          state_reg <= BUSY;
        end

        BUSY: begin
          // done is checked first so a done landing on the final timer
          // cycle still completes normally.
          if (spi_done) begin
            state_reg <= CAPTURE;
          end else if (timer_reg == '0) begin
            rsp_data     <= ERR_DATA;
            err_flag_reg <= 1'b1;
            state_reg    <= RESP;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end

        CAPTURE: begin
          // The master presents rd_data one cycle after done.
          rsp_data  <= spi_rd_data;
          state_reg <= RESP;
        end

        RESP: begin
          last_idx_reg <= cur_idx_reg;
          grant        <= '0;
          err_flag_reg <= 1'b0;
          state_reg    <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          grant     <= '0;
        end
      endcase
    end
  end

endmodule
